// File: rtl/pixel_stream_aligner_if.sv
// Upstream pixel stream: 18-bit GRB pixel with start-of-frame marker and a
// valid/ready handshake. The producer uses the master modport, the aligner
// uses the slave modport.
interface pixel_stream_aligner_if;
  logic [17:0] s_pixel;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_pixel, output s_sof, output s_valid, input s_ready);
  modport slave  (input s_pixel, input s_sof, input s_valid, output s_ready);
endinterface

// File: rtl/pixel_stream_aligner.sv
// Pixel stream aligner: buffers upstream pixels in a small FIFO and locks the
// first pixel of each frame to the first active (DE) cycle after VSync ends,
// producing the 21-bit {hsync, vsync, de, G, R, B} word for the LVDS
// serializer. Underflow during a frame emits black and is counted.
module pixel_stream_aligner #(
  parameter int ScreenX   = 1366,
  parameter int ScreenY   = 768,
  parameter int FifoDepth = 16,
  parameter int SyncOn    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_stream_aligner_if.slave up,
  input  logic                  tim_de,
  input  logic                  tim_hsync,
  input  logic                  tim_vsync,
  output logic [20:0]           video_data,
  output logic                  frame_synced,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam int          AW      = $clog2(FifoDepth);
  localparam logic [20:0] Total   = 21'(ScreenX * ScreenY);
  localparam logic        SyncLvl = (SyncOn != 0);
  localparam logic        SyncOff = !SyncLvl;

  typedef enum logic [1:0] {SEEK, ARM, RUN} state_t;

  state_t        state_q, state_d;
  logic [18:0]   mem [FifoDepth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q;
  logic          push, pop, empty;
  logic          head_sof;
  logic [17:0]   head_px;
  logic          vsync_q, vsync_end;
  logic          armed_q, armed_d;
  logic [20:0]   pixel_cnt_q, pixel_cnt_d;
  logic          out_px, uf_hit;
  logic [20:0]   video_p1;

  // Counter step that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign push         = up.s_valid && ready_q;
  assign empty        = (count_q == '0);
  assign head_sof     = mem[rd_ptr_q][18];
  assign head_px      = mem[rd_ptr_q][17:0];
  assign count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign vsync_end    = (vsync_q == SyncLvl) && (tim_vsync == SyncOff);
  assign up.s_ready   = ready_q;
  assign frame_synced = (state_q == RUN);
  assign video_data   = video_p1;

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {up.s_sof, up.s_pixel};
  end

  // FIFO pointers and occupancy; ready is registered so a pop never reaches it
  // combinationally, and a slot freed this cycle is offered next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != (AW+1)'(FifoDepth));
    end
  end

  // Alignment state, frame pixel counter and VSync edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEEK;
      pixel_cnt_q <= '0;
      armed_q     <= 1'b0;
      vsync_q     <= SyncOff;
    end else begin
      state_q     <= state_d;
      pixel_cnt_q <= pixel_cnt_d;
      armed_q     <= armed_d;
      vsync_q     <= tim_vsync;
    end
  end

  // Next-state logic: hunt for SOF, wait for end of VSync, then stream.
  always_comb begin
    state_d     = state_q;
    pixel_cnt_d = pixel_cnt_q;
    armed_d     = 1'b0;
    pop         = 1'b0;
    out_px      = 1'b0;
    uf_hit      = 1'b0;
    unique case (state_q)
      SEEK: begin
        if (!empty) begin
          if (head_sof) state_d = ARM;
          else          pop     = 1'b1;
        end
      end
      ARM: begin
        armed_d = armed_q || vsync_end;
        if (tim_de && armed_q && !empty) begin
          pop         = 1'b1;
          out_px      = 1'b1;
          armed_d     = 1'b0;
          pixel_cnt_d = 21'd1;
          state_d     = RUN;
          if (pixel_cnt_d == Total) begin
            state_d     = SEEK;
            pixel_cnt_d = '0;
          end
        end
      end
      RUN: begin
        if (!empty && head_sof && pixel_cnt_q != '0) begin
          // Early SOF: abandon this frame and realign on the new one.
          state_d     = ARM;
          pixel_cnt_d = '0;
        end else if (tim_de) begin
          pixel_cnt_d = pixel_cnt_q + 21'd1;
          if (empty) uf_hit = 1'b1;
          else begin
            pop    = 1'b1;
            out_px = 1'b1;
          end
          if (pixel_cnt_d == Total) begin
            state_d     = SEEK;
            pixel_cnt_d = '0;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // Sticky underflow flag and saturating underflow cycle count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else if (uf_hit) begin
      underflow       <= 1'b1;
      underflow_count <= sat_inc16(underflow_count);
    end
  end

  // Output stage: timing bits pass through one cycle late; RGB black outside DE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) video_p1 <= {SyncOff, SyncOff, 1'b0, 18'h0};
    else      video_p1 <= {tim_hsync, tim_vsync, tim_de,
                           (tim_de && out_px) ? head_px : 18'h0};
  end

endmodule

// File: tb/tb_pixel_stream_aligner.sv
// Bench for pixel_stream_aligner (4x2 screen, 4-deep FIFO, active-low syncs).
// A queue-based reference model predicts every output each cycle; directed
// checks pin the key scenarios to hand-derived constants.
module tb_pixel_stream_aligner;
  localparam int  SX = 4, SY = 2, DEPTH = 4, TOTAL = SX * SY;
  localparam bit  SYNC = 1'b0;

  logic clk, rst;
  logic tim_de, tim_hsync, tim_vsync;
  logic [20:0] video_data;
  logic frame_synced, underflow;
  logic [15:0] underflow_count;

  pixel_stream_aligner_if bus ();

  pixel_stream_aligner #(.ScreenX(SX), .ScreenY(SY), .FifoDepth(DEPTH), .SyncOn(0)) dut (
    .clk(clk), .rst(rst), .up(bus.slave),
    .tim_de(tim_de), .tim_hsync(tim_hsync), .tim_vsync(tim_vsync),
    .video_data(video_data), .frame_synced(frame_synced),
    .underflow(underflow), .underflow_count(underflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Source of pixels waiting to be offered upstream.
  logic [18:0] src[$];
  bit src_en = 1'b1, rand_en = 1'b0;
  int dut_acc = 0;

  // Reference model state.
  logic [18:0] q[$];
  bit m_ready, m_locked, m_waiting, m_blank_seen, m_prev_vs, m_uf;
  int m_count;
  logic [15:0] m_ufc;
  logic [20:0] exp_video;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 0; m_locked = 0; m_waiting = 0; m_blank_seen = 0;
    m_prev_vs = !SYNC; m_uf = 0; m_ufc = 0; m_count = 0;
    exp_video = {!SYNC, !SYNC, 1'b0, 18'h0};
  endtask

  // One clock of the frame-alignment rules, evaluated on pre-edge inputs.
  task automatic model_step(output bit acc);
    logic [17:0] rgb;
    logic [18:0] e;
    int avail;
    bit vs_end;
    rgb    = '0;
    avail  = q.size();
    acc    = bus.s_valid && m_ready;
    vs_end = (m_prev_vs == SYNC) && (tim_vsync != SYNC);
    if (!m_locked && !m_waiting) begin
      if (avail > 0) begin
        if (q[0][18]) begin m_waiting = 1; m_blank_seen = 0; end
        else void'(q.pop_front());
      end
    end else if (m_waiting) begin
      if (tim_de && m_blank_seen && avail > 0) begin
        e = q.pop_front(); rgb = e[17:0];
        m_waiting = 0; m_locked = 1; m_count = 1; m_blank_seen = 0;
        if (m_count == TOTAL) begin m_locked = 0; m_count = 0; end
      end else if (vs_end) m_blank_seen = 1;
    end else begin
      if (avail > 0 && q[0][18] && m_count != 0) begin
        m_locked = 0; m_waiting = 1; m_blank_seen = 0; m_count = 0;
      end else if (tim_de) begin
        m_count++;
        if (avail > 0) begin e = q.pop_front(); rgb = e[17:0]; end
        else begin m_uf = 1; if (m_ufc != 16'hFFFF) m_ufc++; end
        if (m_count == TOTAL) begin m_locked = 0; m_count = 0; end
      end
    end
    if (acc) q.push_back({bus.s_sof, bus.s_pixel});
    m_ready   = (q.size() < DEPTH);
    exp_video = {tim_hsync, tim_vsync, tim_de, tim_de ? rgb : 18'h0};
    m_prev_vs = tim_vsync;
  endtask

  task automatic check_all();
    chk("video_data", 32'(video_data), 32'(exp_video));
    chk("s_ready", 32'(bus.s_ready), 32'(m_ready));
    chk("frame_synced", 32'(frame_synced), 32'(m_locked));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("underflow_count", 32'(underflow_count), 32'(m_ufc));
  endtask

  task automatic tick();
    bit acc;
    if (rand_en) src_en = ($urandom_range(0, 3) != 0);
    if (src_en && src.size() > 0) begin
      bus.s_valid = 1'b1; bus.s_sof = src[0][18]; bus.s_pixel = src[0][17:0];
    end else begin
      bus.s_valid = 1'b0; bus.s_sof = 1'($urandom); bus.s_pixel = 18'($urandom);
    end
    #3;
    if (bus.s_valid && bus.s_ready) dut_acc++;
    model_step(acc);
    @(posedge clk); #1;
    if (acc) void'(src.pop_front());
    check_all();
  endtask

  task automatic set_tim(input logic hs, input logic vs, input logic de);
    tim_hsync = hs; tim_vsync = vs; tim_de = de;
  endtask
  task automatic idle(input int n);
    set_tim(1, 1, 0); repeat (n) tick();
  endtask
  task automatic vpulse();
    set_tim(1, 0, 0); tick(); tick(); set_tim(1, 1, 0); tick();
  endtask
  task automatic de_tick();
    set_tim(1, 1, 1); tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_video"}, 32'(video_data), 32'h0018_0000);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_frame_synced"}, 32'(frame_synced), 0);
    chk({tag, "_underflow"}, 32'(underflow), 0);
    chk({tag, "_underflow_count"}, 32'(underflow_count), 0);
  endtask

  initial begin
    int acc0, n, g;
    rst = 1'b1; set_tim(1, 1, 0);
    bus.s_valid = 0; bus.s_sof = 0; bus.s_pixel = 0;
    #1 rst = 1'b0;
    #1 check_reset_values("reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;

    // Basic frame: sof pixel 1 then 2..8, each output one cycle after its DE.
    src.push_back({1'b1, 18'd1});
    for (int i = 2; i <= 8; i++) src.push_back({1'b0, 18'(i)});
    idle(6);
    vpulse();
    for (int i = 1; i <= 8; i++) begin
      de_tick();
      chk("frame_px", 32'(video_data[17:0]), 32'(i));
      chk("frame_de_bit", 32'(video_data[18]), 1);
      chk("frame_synced", 32'(frame_synced), (i < 8) ? 1 : 0);
    end
    chk("frame_no_underflow", 32'(underflow), 0);
    idle(1);
    chk("blank_rgb", 32'(video_data[17:0]), 0);

    // Leading non-sof pixels are discarded while seeking.
    for (int i = 0; i < 3; i++) src.push_back({1'b0, 18'($urandom)});
    src.push_back({1'b1, 18'h3F000});
    for (int i = 0; i < 7; i++) src.push_back({1'b0, 18'($urandom)});
    idle(10);
    vpulse();
    de_tick();
    chk("seek_first_px", 32'(video_data[17:0]), 32'h3F000);
    repeat (7) de_tick();

    // Underflow: only two pixels available for a synced frame.
    src.push_back({1'b1, 18'($urandom)});
    src.push_back({1'b0, 18'($urandom)});
    idle(5);
    vpulse();
    de_tick(); de_tick();
    de_tick();
    chk("uf_rgb0", 32'(video_data[17:0]), 0);
    chk("uf_flag", 32'(underflow), 1);
    de_tick();
    chk("uf_rgb1", 32'(video_data[17:0]), 0);
    chk("uf_count", 32'(underflow_count), 2);
    for (int i = 0; i < 4; i++) src.push_back({1'b0, 18'($urandom)});
    idle(6);
    repeat (4) de_tick();
    chk("uf_frame_end", 32'(frame_synced), 0);
    chk("uf_sticky", 32'(underflow), 1);

    // Backpressure: held valid with no DE fills exactly DEPTH entries.
    src.push_back({1'b1, 18'($urandom)});
    for (int i = 0; i < 7; i++) src.push_back({1'b0, 18'($urandom)});
    acc0 = dut_acc;
    idle(6);
    chk("bp_accepted", 32'(dut_acc - acc0), 4);
    chk("bp_ready_low", 32'(bus.s_ready), 0);
    vpulse();
    chk("bp_still_full", 32'(bus.s_ready), 0);
    de_tick();
    chk("bp_ready_after_pop", 32'(bus.s_ready), 1);
    idle(1);
    chk("bp_refilled", 32'(bus.s_ready), 0);
    repeat (7) de_tick();

    // Early SOF at pixel_cnt=2 drops back to ARM and that sof leads the next frame.
    src.push_back({1'b1, 18'h11111});
    src.push_back({1'b0, 18'h22222});
    src.push_back({1'b1, 18'h2ABCD});
    for (int i = 0; i < 7; i++) src.push_back({1'b0, 18'($urandom)});
    idle(5);
    vpulse();
    de_tick(); de_tick();
    chk("early_px2", 32'(video_data[17:0]), 32'h22222);
    de_tick();
    chk("early_black", 32'(video_data[17:0]), 0);
    chk("early_unsynced", 32'(frame_synced), 0);
    idle(2);
    vpulse();
    de_tick();
    chk("early_sof_out", 32'(video_data[17:0]), 32'h2ABCD);
    repeat (7) de_tick();

    // Mid-frame reset drops queued pixels; next frame realigns from scratch.
    src.push_back({1'b1, 18'($urandom)});
    for (int i = 0; i < 5; i++) src.push_back({1'b0, 18'($urandom)});
    idle(6);
    vpulse();
    de_tick(); de_tick();
    rst = 1'b0;
    #1 check_reset_values("midreset");
    src.delete(); bus.s_valid = 1'b0; model_reset();
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    src.push_back({1'b0, 18'($urandom)});
    src.push_back({1'b0, 18'($urandom)});
    src.push_back({1'b1, 18'h15A5A});
    for (int i = 0; i < 7; i++) src.push_back({1'b0, 18'($urandom)});
    idle(8);
    vpulse();
    de_tick();
    chk("realign_first_px", 32'(video_data[17:0]), 32'h15A5A);
    repeat (7) de_tick();

    // Randomized rasters with random gaps, random valid and stray sof markers.
    rand_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      src.push_back({1'b1, 18'($urandom)});
      n = $urandom_range(5, 9);
      for (int k = 0; k < n; k++) src.push_back({($urandom_range(0, 9) == 0), 18'($urandom)});
      vpulse();
      for (int l = 0; l < SY; l++) begin
        for (int p = 0; p < SX; p++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          de_tick();
        end
        g = $urandom_range(1, 3);
        set_tim(0, 1, 0); tick();
        idle(g);
      end
    end
    rand_en = 1'b0; src_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
